add32_sched: RTL and testbench

Two-requester scheduler for the shared 16-bit ripple/CLA adder in the ALU datapath. It accepts 32-bit add/subtract requests from two masters, arbitrates round-robin, and sequences each operation through the single 16-bit adder in two passes: low half, then high half with carry chained. It returns the 32-bit result with carry-out and an optional signed-overflow flag over a valid/ready handshake. The block owns the adder's `a`/`b`/`cin` inputs exclusively; no other logic drives them.

---
 rtl/add32_sched.sv | 146 ++++++++++++++
 tb/tb_add32_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add32_sched.sv
// Two-master round-robin scheduler that runs 32-bit add/sub through a shared 16-bit adder in two passes.
// Optional signed-overflow flag enabled by defining ADD32_SCHED_OVF_EN.
module add32_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic        req1_sub,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_sum,
  output logic        res_cout,
  output logic        res_ovf,
  output logic        res_id
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sub;
  logic        r_carry;
  logic        r_id;
  logic [31:0] r_sum;
  logic        r_cout;

  // The master that was not granted last wins a tie; a lone requester always wins.
  assign w_grant0 = req0_valid && (!req1_valid || r_last);
  assign w_grant1 = req1_valid && (!req0_valid || !r_last);
  assign w_accept = (r_state == IDLE) && (w_grant0 || w_grant1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = LO;
      LO:      w_next = HI;
      HI:      w_next = DONE;
      DONE:    if (res_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    add_a      = 16'd0;
    add_b      = 16'd0;
    add_cin    = 1'b0;
    res_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = rst_n && w_grant0;
        req1_ready = rst_n && w_grant1;
      end
      LO: begin
        add_a   = r_a[15:0];
        add_b   = r_b[15:0];
        add_cin = r_sub;
      end
      HI: begin
        add_a   = r_a[31:16];
        add_b   = r_b[31:16];
        add_cin = r_carry;
      end
      DONE:    res_valid = 1'b1;
      default: res_valid = 1'b0;
    endcase
  end

  // Operand b is stored pre-inverted for subtract so both passes are plain adds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= 1'b1;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_id    <= 1'b0;
      r_sum   <= 32'd0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a    <= w_grant1 ? req1_a : req0_a;
            r_b    <= w_grant1 ? (req1_sub ? ~req1_b : req1_b)
                               : (req0_sub ? ~req0_b : req0_b);
            r_sub  <= w_grant1 ? req1_sub : req0_sub;
            r_id   <= w_grant1;
            r_last <= w_grant1;
          end
        end
        LO: begin
          r_sum[15:0] <= add_sum;
          r_carry     <= add_cout;
        end
        HI: begin
          r_sum[31:16] <= add_sum;
          r_cout       <= add_cout;
        end
        default: r_cout <= r_cout;
      endcase
    end
  end

`ifdef ADD32_SCHED_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_ovf <= 1'b0;
    else if (r_state == HI)  r_ovf <= (r_a[31] == r_b[31]) && (add_sum[15] != r_a[31]);
  end

  assign res_ovf = r_ovf;
`else
  assign res_ovf = 1'b0;
`endif

  assign res_sum  = r_sum;
  assign res_cout = r_cout;
  assign res_id   = r_id;

endmodule

// File: tb/tb_add32_sched.sv
// Self-checking bench for add32_sched: behavioural model compared every cycle plus directed literal checks.
module tb_add32_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_sub;
  logic [31:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [31:0] req1_a, req1_b;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        res_valid, res_ready;
  logic [31:0] res_sum;
  logic        res_cout, res_ovf, res_id;

`ifdef ADD32_SCHED_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  add32_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
    .res_cout(res_cout), .res_ovf(res_ovf), .res_id(res_id)
  );

  // The shared 16-bit adder lives outside the scheduler
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  int nVec  = 0;
  int nFail = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Behavioural model: tracks the pending operation and its age since accept
  logic        mBusy, mLast, mG, mAny, mSub, mId, mCout, mOvf, mLoCarry;
  logic [31:0] mA, mB, mBx, mSum;
  logic [16:0] mLo;
  logic [32:0] mWide;
  longint      mS;
  int          mAge;

  always @(negedge clk) begin
    if (!rst_n) begin
      mBusy = 1'b0;
      mLast = 1'b1;
      checkOutput("rst req0_ready", req0_ready, 0);
      checkOutput("rst req1_ready", req1_ready, 0);
      checkOutput("rst res_valid", res_valid, 0);
      checkOutput("rst add_a", add_a, 0);
      checkOutput("rst add_b", add_b, 0);
      checkOutput("rst add_cin", add_cin, 0);
      checkOutput("rst res_sum", res_sum, 0);
      checkOutput("rst res_cout", res_cout, 0);
      checkOutput("rst res_ovf", res_ovf, 0);
      checkOutput("rst res_id", res_id, 0);
    end else if (!mBusy) begin
      mAny = req0_valid || req1_valid;
      mG   = (req0_valid && req1_valid) ? ~mLast : req1_valid;
      checkOutput("idle req0_ready", req0_ready, mAny && !mG);
      checkOutput("idle req1_ready", req1_ready, mAny && mG);
      checkOutput("idle res_valid", res_valid, 0);
      checkOutput("idle add_a", add_a, 0);
      checkOutput("idle add_b", add_b, 0);
      checkOutput("idle add_cin", add_cin, 0);
      if (mAny) begin
        mA    = mG ? req1_a : req0_a;
        mB    = mG ? req1_b : req0_b;
        mSub  = mG ? req1_sub : req0_sub;
        mBx   = mSub ? ~mB : mB;
        mWide = {1'b0, mA} + {1'b0, mBx} + {32'd0, mSub};
        mSum  = mWide[31:0];
        mCout = mWide[32];
        mLo   = {1'b0, mA[15:0]} + {1'b0, mBx[15:0]} + {16'd0, mSub};
        mLoCarry = mLo[16];
        mS    = mSub ? (longint'($signed(mA)) - longint'($signed(mB)))
                     : (longint'($signed(mA)) + longint'($signed(mB)));
        mOvf  = OVF_ON && ((mS > 64'sd2147483647) || (mS < -64'sd2147483648));
        mId   = mG;
        mLast = mG;
        mBusy = 1'b1;
        mAge  = 1;
      end
    end else begin
      checkOutput("busy req0_ready", req0_ready, 0);
      checkOutput("busy req1_ready", req1_ready, 0);
      if (mAge == 1) begin
        checkOutput("lo res_valid", res_valid, 0);
        checkOutput("lo add_a", add_a, mA[15:0]);
        checkOutput("lo add_b", add_b, mBx[15:0]);
        checkOutput("lo add_cin", add_cin, mSub);
      end else if (mAge == 2) begin
        checkOutput("hi res_valid", res_valid, 0);
        checkOutput("hi add_a", add_a, mA[31:16]);
        checkOutput("hi add_b", add_b, mBx[31:16]);
        checkOutput("hi add_cin", add_cin, mLoCarry);
      end else begin
        checkOutput("done res_valid", res_valid, 1);
        checkOutput("done add_a", add_a, 0);
        checkOutput("done add_b", add_b, 0);
        checkOutput("done add_cin", add_cin, 0);
        checkOutput("done res_sum", res_sum, mSum);
        checkOutput("done res_cout", res_cout, mCout);
        checkOutput("done res_ovf", res_ovf, mOvf);
        checkOutput("done res_id", res_id, mId);
        if (res_ready) mBusy = 1'b0;
      end
      if (mAge < 3) mAge++;
    end
  end

  task automatic waitReady(input logic m);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (m ? req1_ready : req0_ready) ok = 1;
    end
    if (!ok) checkOutput("grant timeout", 0, 1);
  endtask

  task automatic waitResult();
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (res_valid) ok = 1;
    end
    if (!ok) checkOutput("result timeout", 0, 1);
  endtask

  // One full operation from a single master, returning what the consumer saw
  task automatic applyStimulus(input logic m, input logic [31:0] a, input logic [31:0] b, input logic s,
                               output logic [31:0] sum, output logic cout, output logic ovf,
                               output logic id, output logic [15:0] loB, output logic loCin,
                               output int lat);
    int acc;
    @(posedge clk); #1;
    if (m) begin req1_valid = 1; req1_a = a; req1_b = b; req1_sub = s; end
    else   begin req0_valid = 1; req0_a = a; req0_b = b; req0_sub = s; end
    waitReady(m);
    acc = cyc;
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 0;
    @(negedge clk);
    loB   = add_b;
    loCin = add_cin;
    waitResult();
    lat  = cyc - acc;
    sum  = res_sum;
    cout = res_cout;
    ovf  = res_ovf;
    id   = res_id;
  endtask

  logic [31:0] tSum;
  logic        tCout, tOvf, tId, tCin;
  logic [15:0] tLoB;
  int          tLat;
  int          grants[4];
  int          gCyc[4];
  int          ids[4];
  int          nG, nI;

  initial begin
    rst_n = 0; res_ready = 1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_sub = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_sub = 0;
    #1;
    checkOutput("reset res_valid", res_valid, 0);
    checkOutput("reset res_sum", res_sum, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    applyStimulus(0, 32'h0000FFFF, 32'h00000001, 0, tSum, tCout, tOvf, tId, tLoB, tCin, tLat);
    checkOutput("add sum", tSum, 32'h00010000);
    checkOutput("add cout", tCout, 0);
    checkOutput("add id", tId, 0);
    checkOutput("add latency", tLat, 3);

    applyStimulus(0, 32'h7FFFFFFF, 32'h00000001, 0, tSum, tCout, tOvf, tId, tLoB, tCin, tLat);
    checkOutput("ovf sum", tSum, 32'h80000000);
    checkOutput("ovf flag", tOvf, OVF_ON);

    applyStimulus(0, 32'hFFFFFFFF, 32'h00000001, 0, tSum, tCout, tOvf, tId, tLoB, tCin, tLat);
    checkOutput("wrap sum", tSum, 32'h00000000);
    checkOutput("wrap cout", tCout, 1);

    applyStimulus(1, 32'd5, 32'd7, 1, tSum, tCout, tOvf, tId, tLoB, tCin, tLat);
    checkOutput("sub sum", tSum, 32'hFFFFFFFE);
    checkOutput("sub cout", tCout, 0);
    checkOutput("sub ovf", tOvf, 0);
    checkOutput("sub id", tId, 1);
    checkOutput("sub lo add_b", tLoB, 16'hFFF8);
    checkOutput("sub lo add_cin", tCin, 1);

    // Contention: both masters stay valid
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 32'd10;  req0_b = 32'd20; req0_sub = 0;
    req1_valid = 1; req1_a = 32'h100; req1_b = 32'd1;  req1_sub = 1;
    nG = 0; nI = 0;
    for (int k = 0; k < 4; k++) begin grants[k] = 2; ids[k] = 2; gCyc[k] = 0; end
    for (int i = 0; i < 60 && (nG < 4 || nI < 4); i++) begin
      @(negedge clk);
      if (req0_ready && nG < 4) begin grants[nG] = 0; gCyc[nG] = cyc; nG++; end
      if (req1_ready && nG < 4) begin grants[nG] = 1; gCyc[nG] = cyc; nG++; end
      if (res_valid && res_ready && nI < 4) begin ids[nI] = res_id; nI++; end
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("contention grant%0d", k), grants[k], k % 2);
      checkOutput($sformatf("contention id%0d", k), ids[k], k % 2);
    end
    for (int k = 1; k < 4; k++)
      checkOutput($sformatf("contention spacing%0d", k), gCyc[k] - gCyc[k-1], 4);
    repeat (6) @(posedge clk);

    // Backpressure with master 1 waiting behind the stalled result
    res_ready = 0;
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 32'h12345678; req0_b = 32'h11111111; req0_sub = 0;
    waitReady(0);
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 1; req1_a = 32'd100; req1_b = 32'd1; req1_sub = 1;
    waitResult();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("bp res_valid", res_valid, 1);
      checkOutput("bp res_sum", res_sum, 32'h23456789);
      checkOutput("bp req1_ready", req1_ready, 0);
    end
    @(posedge clk); #1 res_ready = 1;
    @(negedge clk);
    checkOutput("bp handshake valid", res_valid, 1);
    @(negedge clk);
    checkOutput("bp resume grant", req1_ready, 1);
    checkOutput("bp valid dropped", res_valid, 0);
    @(posedge clk); #1 req1_valid = 0;
    waitResult();
    checkOutput("bp m1 sum", res_sum, 32'h00000063);
    checkOutput("bp m1 cout", res_cout, 1);
    checkOutput("bp m1 id", res_id, 1);
    @(posedge clk);

    // Async reset during HI of a master-0 operation
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 32'h00010001; req0_b = 32'h00020002; req0_sub = 0;
    waitReady(0);
    @(posedge clk); #1 req0_valid = 0;
    @(posedge clk); #1 rst_n = 0;
    #1;
    checkOutput("hi-rst add_a", add_a, 0);
    checkOutput("hi-rst add_b", add_b, 0);
    checkOutput("hi-rst add_cin", add_cin, 0);
    checkOutput("hi-rst res_sum", res_sum, 0);
    checkOutput("hi-rst res_valid", res_valid, 0);
    checkOutput("hi-rst res_id", res_id, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd2; req0_sub = 0;
    req1_valid = 1; req1_a = 32'd3; req1_b = 32'd4; req1_sub = 0;
    @(negedge clk);
    checkOutput("post-rst grant0", req0_ready, 1);
    checkOutput("post-rst grant1", req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    waitResult();
    checkOutput("post-rst sum", res_sum, 32'd3);
    checkOutput("post-rst id", res_id, 0);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule
